ifu_fetch_queue: RTL and testbench

- Consumer end of the program-counter interface.
- Takes the fetch address from the pc stage and issues in-order requests to instruction memory with a req/gnt/rvalid handshake.
- Buffers returned instructions, together with their addresses, in a DEPTH-entry queue that feeds the decode stage.
- On a redirect (ex jump or prediction failure), drops all queued and in-flight fetches.

---
 rtl/ifu_fetch_queue.sv | 98 +++++++++
 tb/tb_ifu_fetch_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Fetch queue: issues in-order imem requests for pc_i and buffers the returned instructions for decode.
// Grant-to-decode latency is response latency + 1; issue stalls once queued plus owed responses reach DEPTH.
module ifu_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              pc_valid_i,
  output logic              pc_ready_o,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              flush_i,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_inst_o,
  output logic [ADDR_W-1:0] id_instaddr_o,
  input  logic              id_ready_i
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] CAP = PTR_W'(DEPTH);

  logic [ADDR_W-1:0] slot_addr [DEPTH];
  logic [DATA_W-1:0] slot_data [DEPTH];
  logic [DEPTH-1:0]  slot_filled;

  logic [PTR_W-1:0] wr_ptr, fill_ptr, rd_ptr, discard_cnt;
  logic [PTR_W-1:0] used, in_flight, occupancy, owed, flush_discard;
  logic [IDX_W-1:0] wr_idx, fill_idx, rd_idx;
  logic             grant, pop, drop_now;

  assign wr_idx   = wr_ptr[IDX_W-1:0];
  assign fill_idx = fill_ptr[IDX_W-1:0];
  assign rd_idx   = rd_ptr[IDX_W-1:0];

  // Both sums are bounded by DEPTH, so they fit the pointer width without overflow.
  assign used      = wr_ptr - rd_ptr;
  assign in_flight = wr_ptr - fill_ptr;
  assign occupancy = used + discard_cnt;
  assign owed      = discard_cnt + in_flight;

  // On flush, a response arriving in the same cycle settles one of the owed responses.
  assign drop_now      = imem_rvalid_i && (owed != '0);
  assign flush_discard = owed - PTR_W'(drop_now);

  assign imem_req_o  = pc_valid_i && !flush_i && (occupancy < CAP);
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o && imem_gnt_i;
  assign pc_ready_o  = grant;

  assign id_valid_o    = (rd_ptr != fill_ptr) && slot_filled[rd_idx];
  assign id_inst_o     = id_valid_o ? slot_data[rd_idx] : '0;
  assign id_instaddr_o = id_valid_o ? slot_addr[rd_idx] : '0;
  assign pop           = id_valid_o && id_ready_i;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      discard_cnt <= '0;
      slot_filled <= '0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      fill_ptr    <= '0;
      rd_ptr      <= '0;
      discard_cnt <= flush_discard;
      slot_filled <= '0;
    end else begin
      // Grant, fill and pop never target the same slot, so they update independently.
      if (grant) begin
        slot_addr[wr_idx]   <= pc_i;
        slot_filled[wr_idx] <= 1'b0;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (imem_rvalid_i) begin
        if (discard_cnt != '0) begin
          discard_cnt <= discard_cnt - 1'b1;
        end else if (fill_ptr != wr_ptr) begin
          slot_data[fill_idx]   <= imem_rdata_i;
          slot_filled[fill_idx] <= 1'b1;
          fill_ptr              <= fill_ptr + 1'b1;
        end
      end
      if (pop) begin
        slot_filled[rd_idx] <= 1'b0;
        rd_ptr              <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Randomized bench for ifu_fetch_queue: a memory model answers grants in order, and a scoreboard of
// fetches owed to decode is compared against the DUT's issue and decode outputs every cycle.
module tb_ifu_fetch_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int PHASE_LEN = 300;
  localparam int NPHASE    = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic              pc_ready_o;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [DATA_W-1:0] imem_rdata_i;
  logic              flush_i;
  logic              id_valid_o;
  logic [DATA_W-1:0] id_inst_o;
  logic [ADDR_W-1:0] id_instaddr_o;
  logic              id_ready_i;

  ifu_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn),
    .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .flush_i(flush_i),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_instaddr_o(id_instaddr_o),
    .id_ready_i(id_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                stale;
  } fetch_t;

  fetch_t pend_q[$];   // granted, response not yet returned by memory
  fetch_t exp_q[$];    // returned and still owed to decode, in order

  int  checks = 0;
  int  errors = 0;
  int  dut_pops = 0;
  bit  mon_en = 1'b0;
  bit  pc_adv = 1'b0;

  // Per-phase percentages: pc_valid, gnt, rvalid, id_ready, flush, reset.
  int phase_pct [NPHASE][6] = '{
    '{100, 100, 100, 100,  0, 0},
    '{100, 100, 100,   0,  0, 0},
    '{100, 100,  80, 100,  0, 0},
    '{100,  70,  50,  70, 10, 0},
    '{ 80,  20,  60,  60,  5, 0},
    '{ 70,  70,  70,  70,  5, 2},
    '{ 50,  50,  50,  50, 15, 1},
    '{  0, 100, 100, 100,  0, 0}
  };

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  // Monitor: outputs are stable at the falling edge; pops the scoreboard when decode takes the head.
  always @(negedge clk) begin
    if (mon_en) begin
      bit exp_req;
      exp_req = pc_valid_i && !flush_i && ((exp_q.size() + pend_q.size()) < DEPTH);
      chk("imem_req", 64'(imem_req_o), 64'(exp_req));
      chk("pc_ready", 64'(pc_ready_o), 64'(exp_req && imem_gnt_i));
      if (imem_req_o) chk("imem_addr", 64'(imem_addr_o), 64'(pc_i));
      chk("id_valid", 64'(id_valid_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("id_instaddr", 64'(id_instaddr_o), 64'(exp_q[0].addr));
        chk("id_inst", 64'(id_inst_o), 64'(exp_q[0].data));
        if (id_ready_i && rstn && !flush_i) void'(exp_q.pop_front());
      end else begin
        chk("id_inst_idle", 64'(id_inst_o), 64'd0);
        chk("id_instaddr_idle", 64'(id_instaddr_o), 64'd0);
      end
      if (id_valid_o && id_ready_i && rstn && !flush_i) dut_pops++;
    end
  end

  // Memory and reference model: applies what the coming rising edge will do.
  always @(negedge clk) begin
    #1;
    pc_adv = 1'b0;
    if (!rstn) begin
      pend_q.delete();
      exp_q.delete();
    end else if (flush_i) begin
      if (imem_rvalid_i && pend_q.size() != 0) void'(pend_q.pop_front());
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_q.delete();
    end else begin
      if (imem_rvalid_i && pend_q.size() != 0) begin
        fetch_t r;
        r = pend_q.pop_front();
        if (!r.stale) exp_q.push_back(r);
      end
      if (imem_req_o && imem_gnt_i) begin
        fetch_t g;
        g.addr  = pc_i;
        g.data  = $urandom;
        g.stale = 1'b0;
        pend_q.push_back(g);
        pc_adv = 1'b1;
      end
    end
  end

  initial begin
    bit was_flush;
    rstn          = 1'b0;
    pc_i          = '0;
    pc_valid_i    = 1'b0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    flush_i       = 1'b0;
    id_ready_i    = 1'b0;
    was_flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn   = 1'b1;
    mon_en = 1'b1;

    for (int cyc = 0; cyc < NPHASE * PHASE_LEN; cyc++) begin
      int ph;
      ph = cyc / PHASE_LEN;
      @(posedge clk);
      #1;
      if (was_flush) pc_i = $urandom & 32'hFFFF_FFFC;
      else if (pc_adv) pc_i = pc_i + 32'd4;
      rstn          = !roll(phase_pct[ph][5]);
      flush_i       = rstn && roll(phase_pct[ph][4]);
      pc_valid_i    = roll(phase_pct[ph][0]);
      imem_gnt_i    = roll(phase_pct[ph][1]);
      id_ready_i    = roll(phase_pct[ph][3]);
      imem_rvalid_i = (pend_q.size() != 0) && roll(phase_pct[ph][2]);
      imem_rdata_i  = imem_rvalid_i ? pend_q[0].data : $urandom;
      was_flush     = flush_i;
    end

    @(posedge clk);
    #1;
    chk("decode_progress", 64'(dut_pops >= 300), 64'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
